mux4_rr_sched: RTL and testbench

Round-robin scheduler for the shared 4:1 select datapath. Four requesters compete for one output lane. The block holds a registered grant for up to `MAX_BURST` cycles, drives the two-bit select that steers the selected requester's data onto `dout`, and rotates priority fairly. It sits directly in front of the 4:1 steering logic and is the only source of its select lines.

---
 rtl/mux_sched_pkg.sv | 18 +
 rtl/rr_pick4.sv | 32 +++
 rtl/mux4_rr_sched.sv | 129 ++++++++++++
 tb/tb_mux4_rr_sched.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the 4:1 round-robin select scheduler.
//   state_t       : scheduler FSM states (IDLE, GRANT)
//   owner_t       : 2-bit requester index
//   owner_onehot  : converts an owner index to its one-hot request mask
package mux_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef logic [1:0] owner_t;

    function automatic logic [3:0] owner_onehot(input owner_t o);
        return 4'b0001 << o;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick over four requesters.
// The search starts at last+1 (mod 4) and wraps, so "last" gets lowest priority.
//   req   [3:0] : request vector
//   last  [1:0] : previous owner index
//   idx   [1:0] : chosen requester (equals last when nothing is found)
//   found       : high when any request bit is set
module rr_pick4
    import mux_sched_pkg::*;
(
    input  logic [3:0] req,
    input  owner_t     last,
    output owner_t     idx,
    output logic       found
);

    owner_t cand;

    always_comb begin
        idx   = last;
        found = 1'b0;
        cand  = last;
        // k = 1,2,3,4 maps to offsets 1,2,3,0 so "last" itself is tried last
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last + owner_t'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler driving the select of a shared 4:1 datapath.
// Holds a registered one-hot grant for at most MAX_BURST cycles while other
// requesters wait, then rotates to the next pending requester.
//   clk, rst_n      : clock (rising edge) and asynchronous active-low reset
//   req  [3:0]      : level-sensitive requests, bit i = requester i
//   din0..din3      : requester data lanes, DW bits each
//   gnt  [3:0]      : registered one-hot grant, or zero when idle
//   sel  [1:0]      : registered owner index; holds its value while idle
//   dout [DW-1:0]   : combinational din[sel]
//   dout_valid      : |(gnt & req)
//   busy            : high while in GRANT
module mux4_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    input  logic [DW-1:0] din3,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          busy
);

    localparam int unsigned CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    state_t        state;
    owner_t        last;
    logic [CW-1:0] cnt;

    owner_t     pick_all_idx;
    logic       pick_all_found;
    owner_t     pick_oth_idx;
    logic       pick_oth_found;
    logic [3:0] req_others;

    // In GRANT, sel is the current owner; mask it out for burst-expiry handoff.
    assign req_others = req & ~owner_onehot(sel);

    rr_pick4 u_pick_all (
        .req   (req),
        .last  (last),
        .idx   (pick_all_idx),
        .found (pick_all_found)
    );

    rr_pick4 u_pick_oth (
        .req   (req_others),
        .last  (last),
        .idx   (pick_oth_idx),
        .found (pick_oth_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 2'b11;
            cnt   <= '0;
            gnt   <= '0;
            sel   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_all_found) begin
                        state <= GRANT;
                        sel   <= pick_all_idx;
                        gnt   <= owner_onehot(pick_all_idx);
                        last  <= pick_all_idx;
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (!req[sel]) begin
                        // Owner released; req already excludes it, so a full pick
                        // hands off without a gap cycle.
                        if (pick_all_found) begin
                            sel  <= pick_all_idx;
                            gnt  <= owner_onehot(pick_all_idx);
                            last <= pick_all_idx;
                            cnt  <= '0;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                            cnt   <= '0;
                        end
                    end else if (cnt == CNT_LAST) begin
                        if (pick_oth_found) begin
                            sel  <= pick_oth_idx;
                            gnt  <= owner_onehot(pick_oth_idx);
                            last <= pick_oth_idx;
                        end else begin
                            last <= sel;
                        end
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        dout = din0;
        case (sel)
            2'd0:    dout = din0;
            2'd1:    dout = din1;
            2'd2:    dout = din2;
            default: dout = din3;
        endcase
    end

    assign dout_valid = |(gnt & req);
    assign busy       = (state == GRANT);

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched: one instance at MAX_BURST=4, one at MAX_BURST=1.
module tb_mux4_rr_sched;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] req1;
    logic [7:0] din0, din1, din2, din3;

    logic [3:0] gnt, gnt1;
    logic [1:0] sel, sel1;
    logic [7:0] dout, dout1;
    logic       dout_valid, dout_valid1;
    logic       busy, busy1;

    int errors;
    int checks;

    mux4_rr_sched #(.DW(8), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din0       (din0),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .gnt        (gnt),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    mux4_rr_sched #(.DW(8), .MAX_BURST(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req1),
        .din0       (din0),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .gnt        (gnt1),
        .sel        (sel1),
        .dout       (dout1),
        .dout_valid (dout_valid1),
        .busy       (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        req1  = 4'b0000;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        req    = 4'b0000;
        req1   = 4'b0000;
        din0   = 8'hA0;
        din1   = 8'hB1;
        din2   = 8'hC2;
        din3   = 8'hD3;

        // Reset values
        step();
        check("rst_gnt",   32'(gnt),        32'h0);
        check("rst_sel",   32'(sel),        32'h0);
        check("rst_busy",  32'(busy),       32'h0);
        check("rst_valid", 32'(dout_valid), 32'h0);
        check("rst_dout",  32'(dout),       32'hA0);
        rst_n = 1'b1;

        // Single requester 2 holds indefinitely
        req = 4'b0100;
        step();
        check("r2_gnt",   32'(gnt),        32'h4);
        check("r2_sel",   32'(sel),        32'h2);
        check("r2_dout",  32'(dout),       32'hC2);
        check("r2_busy",  32'(busy),       32'h1);
        check("r2_valid", 32'(dout_valid), 32'h1);
        for (int i = 0; i < 9; i++) begin
            step();
            check("r2_hold", 32'(gnt), 32'h4);
        end
        req = 4'b0000;
        step();
        check("r2_rel_gnt",  32'(gnt),  32'h0);
        check("r2_rel_busy", 32'(busy), 32'h0);
        check("r2_rel_sel",  32'(sel),  32'h2);

        // All four requesting: runs of 4 cycles, owners 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("rr_gnt", 32'(gnt), 32'(4'b0001 << (((k - 1) / 4) % 4)));
            check("rr_sel", 32'(sel), 32'(((k - 1) / 4) % 4));
        end

        // Owner 1 drops mid-burst with req[3] pending
        do_reset();
        req = 4'b1010;
        step();
        check("drop_g1", 32'(gnt), 32'h2);
        step();
        check("drop_g2", 32'(gnt), 32'h2);
        req = 4'b1000;
        step();
        check("drop_hand", 32'(gnt), 32'h8);
        check("drop_dout", 32'(dout), 32'hD3);
        req = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step();
            check("drop_hold3", 32'(gnt), 32'h8);
        end
        step();
        check("drop_next1", 32'(gnt), 32'h2);

        // Only req[0], released after 2 cycles
        do_reset();
        req = 4'b0001;
        step();
        check("r0_g1", 32'(gnt), 32'h1);
        din0 = 8'h5A;
        #1;
        check("r0_dout_comb", 32'(dout), 32'h5A);
        step();
        check("r0_g2", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();
        check("r0_rel_gnt",   32'(gnt),        32'h0);
        check("r0_rel_busy",  32'(busy),       32'h0);
        check("r0_rel_sel",   32'(sel),        32'h0);
        check("r0_rel_valid", 32'(dout_valid), 32'h0);
        din0 = 8'hA0;

        // Asynchronous reset mid-burst with owner 2
        do_reset();
        req = 4'b0100;
        step();
        step();
        check("ar_pre_gnt", 32'(gnt), 32'h4);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_gnt",   32'(gnt),        32'h0);
        check("ar_sel",   32'(sel),        32'h0);
        check("ar_busy",  32'(busy),       32'h0);
        check("ar_valid", 32'(dout_valid), 32'h0);
        req = 4'b0101;
        #1;
        rst_n = 1'b1;
        step();
        check("ar_first", 32'(gnt), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ar_hold0", 32'(gnt), 32'h1);
        end
        step();
        check("ar_next2", 32'(gnt), 32'h4);
        check("ar_sel2",  32'(sel), 32'h2);

        // MAX_BURST=1 instance alternates 0,1 every cycle
        do_reset();
        req1 = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            step();
            check("mb1_gnt", 32'(gnt1), 32'((k % 2 == 0) ? 4'b0001 : 4'b0010));
            check("mb1_dout", 32'(dout1), 32'((k % 2 == 0) ? 8'hA0 : 8'hB1));
        end
        req1 = 4'b0000;
        step();
        check("mb1_idle", 32'(busy1), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
